instr_queue: RTL and testbench

//  Instruction queue directly downstream of the fetch stage. Buffers {pc, ir} pairs

---
 rtl/lc3b_types.sv | 11 +
 rtl/iq_ptr.sv | 25 ++
 rtl/instr_queue.sv | 82 ++++++++
 tb/tb_instr_queue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the 16-bit machine word and the instruction-queue entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_iq_entry;

endpackage

// File: rtl/iq_ptr.sv
// Wrapping PTR_W-bit pointer for the instruction queue; clr takes priority over inc.
module iq_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Overflow past DEPTH-1 wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/instr_queue.sv
// In-order {pc, ir} buffer between fetch and decode, first-word-fall-through, with flush.
module instr_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq,
  input  lc3b_word                 enq_pc,
  input  lc3b_word                 enq_ir,
  input  logic                     deq,
  output logic                     head_valid,
  output lc3b_word                 head_pc,
  output lc3b_word                 head_ir,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

  lc3b_iq_entry     mem [DEPTH];
  lc3b_iq_entry     head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq_acc;
  logic             deq_acc;

  // Full blocks enq regardless of deq so the fetch stall never depends on deq.
  assign enq_acc = enq & ~full & ~flush;
  assign deq_acc = deq & ~empty & ~flush;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  iq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (enq_acc),
    .ptr   (wr_ptr)
  );

  iq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (deq_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (enq_acc) begin
      mem[wr_ptr] <= '{pc: enq_pc, ir: enq_ir};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({enq_acc, deq_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Stale storage is hidden behind the empty mask so the head reads zero when idle.
  assign head       = empty ? '0 : mem[rd_ptr];
  assign head_valid = ~empty;
  assign head_pc    = head.pc;
  assign head_ir    = head.ir;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: a reference queue tracks accepted entries and head/flags.
module tb_instr_queue;
  import lc3b_types::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       enq;
  lc3b_word   enq_pc;
  lc3b_word   enq_ir;
  logic       deq;
  logic       head_valid;
  lc3b_word   head_pc;
  lc3b_word   head_ir;
  logic       full;
  logic       empty;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  lc3b_iq_entry model[$];

  instr_queue #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .enq        (enq),
    .enq_pc     (enq_pc),
    .enq_ir     (enq_ir),
    .deq        (deq),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_ir    (head_ir),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle from just after a rising edge, checks mid-cycle, updates the model at the edge.
  task automatic cycle(input logic e, input lc3b_word pc, input lc3b_word ir,
                       input logic d, input logic f);
    int n;
    lc3b_iq_entry ent;
    enq = e; enq_pc = pc; enq_ir = ir; deq = d; flush = f;
    @(negedge clk);
    n = model.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("head_valid", 32'(head_valid), 32'(n != 0));
    chk("head_pc", 32'(head_pc), (n != 0) ? 32'(model[0].pc) : 32'h0);
    chk("head_ir", 32'(head_ir), (n != 0) ? 32'(model[0].ir) : 32'h0);
    @(posedge clk);
    if (f) begin
      model.delete();
    end else begin
      if (d && n > 0) void'(model.pop_front());
      if (e && n < 8) begin
        ent.pc = pc;
        ent.ir = ir;
        model.push_back(ent);
      end
    end
    #1;
    enq = 1'b0; deq = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; enq = 1'b0; deq = 1'b0;
    enq_pc = '0; enq_ir = '0;
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_head_valid", 32'(head_valid), 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-run asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h2000 + 16'(i), 16'h0A00 + 16'(i), 1'b0, 1'b0);
    #3;
    chk("pre_rst_count", 32'(count), 32'h5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_full", 32'(full), 32'h0);
    chk("async_rst_empty", 32'(empty), 32'h1);
    chk("async_rst_head_pc", 32'(head_pc), 32'h0);
    model.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle();

    // Fill to full, drop a ninth enq, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h3000 + 16'(2*i), 16'h1000 + 16'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    cycle(1'b1, 16'h3010, 16'h1008, 1'b0, 1'b0);
    chk("drop_count", 32'(count), 32'h8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();
    chk("drain_empty", 32'(empty), 32'h1);

    // Steady state at count 3 with simultaneous enq/deq, pointers wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h6000 + 16'(i), 16'h7000 + 16'(i), 1'b0, 1'b0);
    for (int i = 3; i < 13; i++) cycle(1'b1, 16'h6000 + 16'(i), 16'h7000 + 16'(i), 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'h3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();

    // Full with enq and deq together: deq wins, enq dropped.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h8000 + 16'(i), 16'h9000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'h8100, 16'h9100, 1'b1, 1'b0);
    chk("full_enq_deq_count", 32'(count), 32'h7);
    for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Empty with enq and deq: entry appears only after the edge.
    cycle(1'b1, 16'h4000, 16'h4444, 1'b1, 1'b0);
    chk("empty_enq_deq_count", 32'(count), 32'h1);
    chk("empty_enq_head_pc", 32'(head_pc), 32'h4000);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Flush with six entries and enq/deq in the same cycle.
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'hA100, 16'hB100, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_head_ir", 32'(head_ir), 32'h0);
    cycle(1'b1, 16'h5000, 16'h5555, 1'b0, 1'b0);
    chk("post_flush_head_pc", 32'(head_pc), 32'h5000);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
